min_reduce_sequencer: RTL and testbench

MIN_REDUCE_SEQUENCER -- requirements
Module: min_reduce_sequencer

---
 rtl/min_reduce_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_min_reduce_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_reduce_sequencer.sv
// rtl/min_reduce_sequencer.sv - sequential minimum reduction over channel groups
//
// tree_compare_solver: combinational min of default_value and the valid lanes.
//   values        in  LANES*DATA_WIDTH  lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   valids        in  LANES             lane participates when set
//   default_value in  DATA_WIDTH        floor value, also fills invalid lanes
//   min_value     out DATA_WIDTH        unsigned minimum
//
// min_reduce_sequencer: snapshots CHANNEL_COUNT channels on start and walks them
// LANES at a time through one tree_compare_solver, one group per cycle.
//   clk           in  1                 rising-edge clock
//   reset_n       in  1                 synchronous active-low reset
//   start         in  1                 request a reduction (taken in IDLE or DONE)
//   default_value in  DATA_WIDTH        result when no valid channel is smaller
//   values        in  CHANNEL_COUNT*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valids        in  CHANNEL_COUNT     channel participation mask
//   busy          out 1                 high in RUN and DONE
//   done          out 1                 one-cycle pulse, result valid
//   result        out DATA_WIDTH        minimum of default and valid channels
//   any_valid     out 1                 OR of the snapshot valids

module tree_compare_solver #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 5
) (
  input  logic [LANES*DATA_WIDTH-1:0] values,
  input  logic [LANES-1:0]            valids,
  input  logic [DATA_WIDTH-1:0]       default_value,
  output logic [DATA_WIDTH-1:0]       min_value
);

  // Heap-ordered binary tree: leaves at [LEAVES .. 2*LEAVES-1], root at 1.
  localparam int LEAVES = 1 << $clog2(LANES);

  logic [DATA_WIDTH-1:0] node [1:2*LEAVES-1];

  always_comb begin
    for (int i = 1; i < 2 * LEAVES; i++) begin
      node[i] = default_value;
    end
    // Invalid and padding leaves hold the default, so they can never win below it.
    for (int l = 0; l < LANES; l++) begin
      if (valids[l]) begin
        node[LEAVES + l] = values[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int i = LEAVES - 1; i >= 1; i--) begin
      node[i] = (node[2*i] < node[2*i+1]) ? node[2*i] : node[2*i+1];
    end
    min_value = node[1];
  end

endmodule

module min_reduce_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 12,
  parameter int LANES         = 5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             default_value,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] values,
  input  logic [CHANNEL_COUNT-1:0]          valids,
  output logic                              busy,
  output logic                              done,
  output logic [DATA_WIDTH-1:0]             result,
  output logic                              any_valid
);

  localparam int GROUPS = (CHANNEL_COUNT + LANES - 1) / LANES;
  localparam int GIDX_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PADDED = GROUPS * LANES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [GIDX_W-1:0]                   grp_q, grp_d;
  logic [DATA_WIDTH-1:0]               run_min_q, run_min_d;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] vals_q, vals_d;
  logic [CHANNEL_COUNT-1:0]            valids_q, valids_d;
  logic [DATA_WIDTH-1:0]               result_q, result_d;
  logic                                any_valid_q, any_valid_d;

  logic [PADDED*DATA_WIDTH-1:0]        pad_vals;
  logic [PADDED-1:0]                   pad_valids;
  logic [LANES*DATA_WIDTH-1:0]         grp_vals;
  logic [LANES-1:0]                    grp_valids;
  logic [DATA_WIDTH-1:0]               tree_min;
  logic                                last_grp;
  logic                                accept;
  int unsigned                         grp_base;

  // Lanes past CHANNEL_COUNT in the last group read as value 0, valid 0.
  always_comb begin
    pad_vals                                 = '0;
    pad_vals[CHANNEL_COUNT*DATA_WIDTH-1:0]   = vals_q;
    pad_valids                               = '0;
    pad_valids[CHANNEL_COUNT-1:0]            = valids_q;
    grp_base                                 = 32'(grp_q) * LANES;
    grp_vals   = pad_vals[grp_base*DATA_WIDTH +: LANES*DATA_WIDTH];
    grp_valids = pad_valids[grp_base +: LANES];
  end

  tree_compare_solver #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_tree (
    .values        (grp_vals),
    .valids        (grp_valids),
    .default_value (run_min_q),
    .min_value     (tree_min)
  );

  assign last_grp = (grp_q == GIDX_W'(GROUPS - 1));
  // The DONE cycle also takes a new start so back-to-back runs need no idle gap.
  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grp_q       <= '0;
      run_min_q   <= '0;
      vals_q      <= '0;
      valids_q    <= '0;
      result_q    <= '0;
      any_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      run_min_q   <= run_min_d;
      vals_q      <= vals_d;
      valids_q    <= valids_d;
      result_q    <= result_d;
      any_valid_q <= any_valid_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    run_min_d   = run_min_q;
    vals_d      = vals_q;
    valids_d    = valids_q;
    result_d    = result_q;
    any_valid_d = any_valid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = accept ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        run_min_d = tree_min;
        grp_d     = grp_q + GIDX_W'(1);
        if (last_grp) begin
          state_d     = ST_DONE;
          grp_d       = '0;
          result_d    = tree_min;
          any_valid_d = |valids_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      vals_d    = values;
      valids_d  = valids;
      run_min_d = default_value;
      grp_d     = '0;
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign result    = result_q;
  assign any_valid = any_valid_q;

endmodule

// File: tb/tb_min_reduce_sequencer.sv
// tb/tb_min_reduce_sequencer.sv - self-checking bench for min_reduce_sequencer
//
// Drives directed and random reductions and compares busy/done/result/any_valid
// against a behavioural minimum model. No ports.

module tb_min_reduce_sequencer;

  localparam int DW     = 8;
  localparam int CH     = 12;
  localparam int LN     = 5;
  localparam int GROUPS = 3;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [DW-1:0]      default_value;
  logic [CH*DW-1:0]   values;
  logic [CH-1:0]      valids;
  logic               busy;
  logic               done;
  logic [DW-1:0]      result;
  logic               any_valid;

  int vectors;
  int miscompares;

  min_reduce_sequencer #(
    .DATA_WIDTH    (DW),
    .CHANNEL_COUNT (CH),
    .LANES         (LN)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .default_value (default_value),
    .values        (values),
    .valids        (valids),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .any_valid     (any_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_min(input logic [DW-1:0] d,
                                            input logic [CH*DW-1:0] v,
                                            input logic [CH-1:0] m);
    logic [DW-1:0] r;
    r = d;
    for (int i = 0; i < CH; i++) begin
      if (m[i] && (v[i*DW +: DW] < r)) r = v[i*DW +: DW];
    end
    return r;
  endfunction

  task automatic randomize_inputs();
    int mode;
    mode = $urandom_range(0, 3);
    default_value = DW'($urandom);
    for (int i = 0; i < CH; i++) values[i*DW +: DW] = DW'($urandom);
    case (mode)
      0: valids = '0;
      1: valids = CH'($urandom) & CH'($urandom);
      default: valids = CH'($urandom);
    endcase
  endtask

  // Pulse start for one edge, then wait (bounded) until done is seen.
  task automatic run_reduce(output int lat, output int busy_cycles);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b1;
    randomize_inputs();
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, result, any_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h any_valid=%b, required all 0",
               busy, done, result, any_valid);
    end
    reset_n = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_dropped: busy=%b, required 0", busy);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    default_value = 8'h5A;
    valids = '0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_edge_start: busy=%b, required 1", busy);
    end
    for (int k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || result !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_first_run: done=%b result=%h, required done=1 result=5a", done, result);
    end
    @(negedge clk);
  endtask

  task automatic test_no_valid();
    int lat, bc;
    default_value = 8'h33;
    valids = '0;
    for (int i = 0; i < CH; i++) values[i*DW +: DW] = DW'($urandom);
    run_reduce(lat, bc);
    vectors++;
    if (lat !== GROUPS) begin
      miscompares++;
      $display("FAIL no_valid_latency: got %0d edges, required %0d", lat, GROUPS);
    end
    vectors++;
    if (result !== 8'h33 || any_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_valid_result: result=%h any_valid=%b, required 33/0", result, any_valid);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_single_pulse: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_padded();
    int lat, bc;
    default_value = 8'h33;
    for (int i = 0; i < CH; i++) values[i*DW +: DW] = DW'($urandom);
    values[0*DW +: DW]  = 8'h44;
    values[7*DW +: DW]  = 8'h11;
    values[11*DW +: DW] = 8'h88;
    valids = 12'b1000_1000_0001;
    run_reduce(lat, bc);
    vectors++;
    if (result !== 8'h11 || any_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL padded_result: result=%h any_valid=%b, required 11/1", result, any_valid);
    end
    vectors++;
    if (bc !== GROUPS + 1) begin
      miscompares++;
      $display("FAIL padded_busy_cycles: got %0d, required %0d", bc, GROUPS + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_descending();
    int lat, bc;
    default_value = 8'hFF;
    for (int i = 0; i < CH; i++) values[i*DW +: DW] = DW'(255 - i);
    valids = '1;
    run_reduce(lat, bc);
    vectors++;
    if (result !== 8'hF4 || any_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL descending_result: result=%h any_valid=%b, required f4/1", result, any_valid);
    end
    @(negedge clk);
    default_value = 8'hAA;
    values[11*DW +: DW] = 8'h05;
    valids = 12'h800;
    run_reduce(lat, bc);
    vectors++;
    if (result !== 8'h05) begin
      miscompares++;
      $display("FAIL last_channel_only: result=%h, required 05", result);
    end
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    logic [DW-1:0] exp_r;
    logic          exp_a;
    int            dcount;
    int            dat;
    logic [DW-1:0] got_r;
    randomize_inputs();
    valids = valids | 12'h001;
    exp_r = ref_min(default_value, values, valids);
    exp_a = |valids;
    start = 1'b1;
    dcount = 0;
    dat = -1;
    got_r = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcount++;
        dat = k;
        got_r = result;
      end
      if (k <= 3) begin
        randomize_inputs();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    vectors++;
    if (dcount !== 1 || dat !== 4) begin
      miscompares++;
      $display("FAIL snapshot_done_count: %0d pulses at cycle %0d, required 1 at 4", dcount, dat);
    end
    vectors++;
    if (got_r !== exp_r || any_valid !== exp_a) begin
      miscompares++;
      $display("FAIL snapshot_result: result=%h any_valid=%b, required %h/%b",
               got_r, any_valid, exp_r, exp_a);
    end
  endtask

  task automatic test_reset_abort();
    int            dcount;
    int            lat, bc;
    logic [DW-1:0] exp_r;
    randomize_inputs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, result, any_valid} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b done=%b result=%h any_valid=%b, required all 0",
               busy, done, result, any_valid);
    end
    reset_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    vectors++;
    if (dcount !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: %0d pulses, required 0", dcount);
    end
    randomize_inputs();
    exp_r = ref_min(default_value, values, valids);
    run_reduce(lat, bc);
    vectors++;
    if (lat !== GROUPS || result !== exp_r) begin
      miscompares++;
      $display("FAIL abort_recovery: latency=%0d result=%h, required %0d/%h",
               lat, result, GROUPS, exp_r);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0]    h_d  [0:31];
    logic [CH*DW-1:0] h_v  [0:31];
    logic [CH-1:0]    h_m  [0:31];
    int               last;
    int               dcount;
    logic [DW-1:0]    exp_r;
    last = -1;
    dcount = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k > 0 && done === 1'b1) begin
        dcount++;
        vectors++;
        if (k < 4) begin
          miscompares++;
          $display("FAIL b2b_early_done: done at cycle %0d, required >= 4", k);
        end else begin
          exp_r = ref_min(h_d[k-4], h_v[k-4], h_m[k-4]);
          if (result !== exp_r || any_valid !== (|h_m[k-4])) begin
            miscompares++;
            $display("FAIL b2b_result: cycle %0d result=%h any_valid=%b, required %h/%b",
                     k, result, any_valid, exp_r, |h_m[k-4]);
          end
        end
        if (last >= 0) begin
          vectors++;
          if (k - last !== GROUPS + 1) begin
            miscompares++;
            $display("FAIL b2b_period: %0d cycles, required %0d", k - last, GROUPS + 1);
          end
        end
        last = k;
      end
      randomize_inputs();
      h_d[k] = default_value;
      h_v[k] = values;
      h_m[k] = valids;
      start = 1'b1;
    end
    vectors++;
    if (dcount !== 5) begin
      miscompares++;
      $display("FAIL b2b_done_count: %0d pulses, required 5", dcount);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_random();
    int            lat, bc;
    logic [DW-1:0] exp_r;
    logic          exp_a;
    for (int n = 0; n < 20; n++) begin
      randomize_inputs();
      exp_r = ref_min(default_value, values, valids);
      exp_a = |valids;
      run_reduce(lat, bc);
      vectors++;
      if (lat !== GROUPS || result !== exp_r || any_valid !== exp_a) begin
        miscompares++;
        $display("FAIL random_%0d: latency=%0d result=%h any_valid=%b, required %0d/%h/%b",
                 n, lat, result, any_valid, GROUPS, exp_r, exp_a);
      end
      randomize_inputs();
      repeat (2) @(negedge clk);
      vectors++;
      if (result !== exp_r || any_valid !== exp_a || done !== 1'b0) begin
        miscompares++;
        $display("FAIL random_hold_%0d: result=%h any_valid=%b done=%b, required %h/%b/0",
                 n, result, any_valid, done, exp_r, exp_a);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start = 1'b0;
    default_value = '0;
    values = '0;
    valids = '0;
    test_reset();
    test_no_valid();
    test_padded();
    test_descending();
    test_snapshot();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
